tuple_extractor: RTL

//  Parses raw IPv4 packets arriving as a 32-bit word stream and extracts the TCP/UDP 5-tuple.

---
 rtl/nat_pkg.sv | 26 ++
 rtl/nat_sat_counter.sv | 25 ++
 rtl/tuple_extractor.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nat_pkg.sv
// rtl/nat_pkg.sv - shared parse-state, protocol and tuple word-order definitions
package nat_pkg;

  typedef enum logic [2:0] {
    S_W0,
    S_HDR,
    S_OPT,
    S_L4,
    S_DRAIN
  } parse_state_e;

  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;

  // Word order of an emitted tuple, as consumed by the connection-lookup stage
  localparam logic [1:0] TW_SRCIP = 2'd0;
  localparam logic [1:0] TW_DSTIP = 2'd1;
  localparam logic [1:0] TW_PORTS = 2'd2;
  localparam logic [1:0] TW_PROTO = 2'd3;

  function automatic logic is_l4_proto(input logic [7:0] proto, input logic [7:0] tcp,
                                       input logic [7:0] udp);
    return (proto == tcp) || (proto == udp);
  endfunction

endpackage

// File: rtl/nat_sat_counter.sv
// rtl/nat_sat_counter.sv - saturating event counter, holds at all-ones
module nat_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/tuple_extractor.sv
// rtl/tuple_extractor.sv - IPv4 word-stream parser emitting the TCP/UDP 5-tuple
module tuple_extractor #(
  parameter int         CNT_W     = 16,
  parameter logic [7:0] PROTO_TCP = nat_pkg::PROTO_TCP,
  parameter logic [7:0] PROTO_UDP = nat_pkg::PROTO_UDP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pkt_valid_i,
  input  logic [31:0]      pkt_data_i,
  input  logic             pkt_last_i,
  output logic             pkt_ready_o,
  output logic             tuple_valid_o,
  output logic [31:0]      tuple_data_o,
  input  logic             tuple_ready_i,
  output logic [CNT_W-1:0] pkt_count_o,
  output logic [CNT_W-1:0] drop_count_o
);
  import nat_pkg::*;

  parse_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d, ihl_q, ihl_d;
  logic         bad_q, bad_d;
  logic [7:0]   proto_q, proto_d;
  logic [31:0]  src_q, src_d, dst_q, dst_d;

  // Emit set is separate so the next header can be parsed while a tuple drains
  logic [31:0]  e_src_q, e_src_d, e_dst_q, e_dst_d, e_ports_q, e_ports_d;
  logic [7:0]   e_proto_q, e_proto_d;
  logic         pending_q, pending_d;
  logic [1:0]   out_idx_q, out_idx_d;

  logic acc, emit_hs, pkt_inc, drop_inc;

  assign pkt_ready_o   = !((state_q == S_L4) && pending_q);
  assign acc           = pkt_valid_i && pkt_ready_o;
  assign emit_hs       = pending_q && tuple_ready_i;
  assign tuple_valid_o = pending_q;

  always_comb begin
    tuple_data_o = e_src_q;
    case (out_idx_q)
      TW_SRCIP: tuple_data_o = e_src_q;
      TW_DSTIP: tuple_data_o = e_dst_q;
      TW_PORTS: tuple_data_o = e_ports_q;
      TW_PROTO: tuple_data_o = {24'b0, e_proto_q};
      default:  tuple_data_o = e_src_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ihl_d     = ihl_q;
    bad_d     = bad_q;
    proto_d   = proto_q;
    src_d     = src_q;
    dst_d     = dst_q;
    e_src_d   = e_src_q;
    e_dst_d   = e_dst_q;
    e_ports_d = e_ports_q;
    e_proto_d = e_proto_q;
    pending_d = pending_q;
    out_idx_d = out_idx_q;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;

    if (emit_hs) begin
      out_idx_d = out_idx_q + 2'd1;
      if (out_idx_q == TW_PROTO) pending_d = 1'b0;
    end

    if (acc) begin
      idx_d = idx_q + 4'd1;
      case (state_q)
        S_W0: begin
          ihl_d   = pkt_data_i[27:24];
          bad_d   = (pkt_data_i[31:28] != 4'd4) || (pkt_data_i[27:24] < 4'd5);
          idx_d   = 4'd1;
          state_d = S_HDR;
        end
        S_HDR: begin
          if (idx_q == 4'd2) begin
            proto_d = pkt_data_i[23:16];
            if (!is_l4_proto(pkt_data_i[23:16], PROTO_TCP, PROTO_UDP)) bad_d = 1'b1;
          end
          if (idx_q == 4'd3) src_d = pkt_data_i;
          if (idx_q == 4'd4) begin
            dst_d = pkt_data_i;
            // An illegal IHL below 5 is already marked bad; treat it like 5 so it reaches S_L4
            state_d = (ihl_q <= 4'd5) ? S_L4 : S_OPT;
          end
        end
        S_OPT: begin
          if (idx_q == ihl_q - 4'd1) state_d = S_L4;
        end
        S_L4: begin
          if (!bad_q) begin
            e_src_d   = src_q;
            e_dst_d   = dst_q;
            e_ports_d = {pkt_data_i[15:0], pkt_data_i[31:16]};
            e_proto_d = proto_q;
            pending_d = 1'b1;
            out_idx_d = TW_SRCIP;
            pkt_inc   = 1'b1;
          end else begin
            drop_inc  = 1'b1;
          end
          state_d = S_DRAIN;
        end
        default: ;
      endcase
      if (pkt_last_i) begin
        state_d = S_W0;
        if ((state_q == S_W0) || (state_q == S_HDR) || (state_q == S_OPT)) drop_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_W0;
      idx_q     <= '0;
      ihl_q     <= '0;
      bad_q     <= 1'b0;
      proto_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      e_src_q   <= '0;
      e_dst_q   <= '0;
      e_ports_q <= '0;
      e_proto_q <= '0;
      pending_q <= 1'b0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ihl_q     <= ihl_d;
      bad_q     <= bad_d;
      proto_q   <= proto_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      e_src_q   <= e_src_d;
      e_dst_q   <= e_dst_d;
      e_ports_q <= e_ports_d;
      e_proto_q <= e_proto_d;
      pending_q <= pending_d;
      out_idx_q <= out_idx_d;
    end
  end

  nat_sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (pkt_inc),
    .count_o (pkt_count_o)
  );

  nat_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (drop_inc),
    .count_o (drop_count_o)
  );

endmodule
